// File: rtl/lc3_mem_arbiter_if.sv
// Request/acknowledge bundle used by each requester of the LC-3 memory arbiter.
// The requester uses the master modport and the arbiter uses the slave modport.
interface lc3_mem_arbiter_if #(
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned DATA_W = 16
);
  logic              req;
  logic              we;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic              ack;
  logic [DATA_W-1:0] rdata;

  modport master (
    output req,
    output we,
    output addr,
    output wdata,
    input  ack,
    input  rdata
  );

  modport slave (
    input  req,
    input  we,
    input  addr,
    input  wdata,
    output ack,
    output rdata
  );
endinterface

// File: rtl/lc3_mem_arbiter.sv
// Two-port (CPU / loader) arbiter for the single LC-3 memory port.
// Define MEMARB_LDR_PRIORITY_EN for fixed loader priority on ties; default is round-robin.
module lc3_mem_arbiter #(
  parameter int unsigned ADDR_W  = 16,
  parameter int unsigned DATA_W  = 16,
  parameter int unsigned MEM_LAT = 2
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  lc3_mem_arbiter_if.slave  cpu_if,
  lc3_mem_arbiter_if.slave  ldr_if,
  output logic              mem_en_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic [DATA_W-1:0] mem_rdata_i,
  output logic              busy_o,
  output logic              owner_o
);

  typedef enum logic [1:0] {StIdle, StAccess, StResp} state_e;

  state_e            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              owner_q, owner_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] cpu_rdata_q, cpu_rdata_d;
  logic [DATA_W-1:0] ldr_rdata_q, ldr_rdata_d;

  logic any_req;
  logic grant_ldr;

  // owner_q doubles as last_owner: it is only rewritten at grant time.
  always_comb begin
    any_req = cpu_if.req | ldr_if.req;
    if (cpu_if.req && ldr_if.req) begin
`ifdef MEMARB_LDR_PRIORITY_EN
      grant_ldr = 1'b1;
`else
      grant_ldr = ~owner_q;
`endif
    end else begin
      grant_ldr = ldr_if.req;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    owner_d     = owner_q;
    we_d        = we_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    cpu_rdata_d = cpu_rdata_q;
    ldr_rdata_d = ldr_rdata_q;

    unique case (state_q)
      StIdle: begin
        if (any_req) begin
          owner_d = grant_ldr;
          cnt_d   = 4'(MEM_LAT - 1);
          state_d = StAccess;
          if (grant_ldr) begin
            we_d    = ldr_if.we;
            addr_d  = ldr_if.addr;
            wdata_d = ldr_if.wdata;
          end else begin
            we_d    = cpu_if.we;
            addr_d  = cpu_if.addr;
            wdata_d = cpu_if.wdata;
          end
        end
      end
      StAccess: begin
        if (cnt_q == 4'd0) begin
          state_d = StResp;
          if (!we_q) begin
            if (owner_q) ldr_rdata_d = mem_rdata_i;
            else         cpu_rdata_d = mem_rdata_i;
          end
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      StResp: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q     <= StIdle;
      cnt_q       <= 4'd0;
      owner_q     <= 1'b0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      cpu_rdata_q <= '0;
      ldr_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      owner_q     <= owner_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      cpu_rdata_q <= cpu_rdata_d;
      ldr_rdata_q <= ldr_rdata_d;
    end
  end

  always_comb begin
    mem_en_o     = (state_q == StAccess);
    mem_we_o     = (state_q == StAccess) && we_q;
    mem_addr_o   = addr_q;
    mem_wdata_o  = wdata_q;
    busy_o       = (state_q != StIdle);
    owner_o      = owner_q;
    cpu_if.ack   = (state_q == StResp) && !owner_q;
    ldr_if.ack   = (state_q == StResp) && owner_q;
    cpu_if.rdata = cpu_rdata_q;
    ldr_if.rdata = ldr_rdata_q;
  end

endmodule

// File: tb/tb_lc3_mem_arbiter.sv
// Directed self-checking bench for lc3_mem_arbiter with MEM_LAT = 2.
module tb_lc3_mem_arbiter;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        mem_en, mem_we, busy, owner;
  logic [15:0] mem_addr, mem_wdata, mem_rdata;
  int          checks = 0;
  int          errors = 0;

  lc3_mem_arbiter_if #(.ADDR_W(16), .DATA_W(16)) cpu_if ();
  lc3_mem_arbiter_if #(.ADDR_W(16), .DATA_W(16)) ldr_if ();

  lc3_mem_arbiter #(.ADDR_W(16), .DATA_W(16), .MEM_LAT(2)) dut (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .cpu_if     (cpu_if),
    .ldr_if     (ldr_if),
    .mem_en_o   (mem_en),
    .mem_we_o   (mem_we),
    .mem_addr_o (mem_addr),
    .mem_wdata_o(mem_wdata),
    .mem_rdata_i(mem_rdata),
    .busy_o     (busy),
    .owner_o    (owner)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog obs=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  int          n;
  int          t[3];
  logic        exp_own;

  initial begin
    rst_n = 1'b0;
    cpu_if.req = 1'b0; cpu_if.we = 1'b0; cpu_if.addr = '0; cpu_if.wdata = '0;
    ldr_if.req = 1'b0; ldr_if.we = 1'b0; ldr_if.addr = '0; ldr_if.wdata = '0;
    mem_rdata = 16'h0000;
    tick(); tick();
    chk("rst_mem_en", mem_en, 0);
    chk("rst_busy", busy, 0);
    chk("rst_owner", owner, 0);
    chk("rst_addr", mem_addr, 0);
    chk("rst_cpu_rdata", cpu_if.rdata, 0);
    chk("rst_acks", {cpu_if.ack, ldr_if.ack}, 0);
    rst_n = 1'b1;

    // 1: CPU read
    cpu_if.req = 1'b1; cpu_if.we = 1'b0; cpu_if.addr = 16'h3000; mem_rdata = 16'hE207;
    tick();
    chk("t1_en_c1", mem_en, 1);
    chk("t1_we_c1", mem_we, 0);
    chk("t1_addr", mem_addr, 16'h3000);
    chk("t1_owner", owner, 0);
    chk("t1_ack_early", cpu_if.ack, 0);
    tick();
    chk("t1_en_c2", mem_en, 1);
    tick();
    chk("t1_en_resp", mem_en, 0);
    chk("t1_cpu_ack", cpu_if.ack, 1);
    chk("t1_ldr_ack", ldr_if.ack, 0);
    chk("t1_rdata", cpu_if.rdata, 16'hE207);
    chk("t1_busy_resp", busy, 1);
    cpu_if.req = 1'b0;
    tick();
    chk("t1_ack_clr", cpu_if.ack, 0);
    chk("t1_busy_idle", busy, 0);

    // 2: loader write
    ldr_if.req = 1'b1; ldr_if.we = 1'b1; ldr_if.addr = 16'h3001; ldr_if.wdata = 16'h3200;
    mem_rdata = 16'hBEEF;
    tick();
    chk("t2_en_c1", mem_en, 1);
    chk("t2_we_c1", mem_we, 1);
    chk("t2_addr", mem_addr, 16'h3001);
    chk("t2_wdata", mem_wdata, 16'h3200);
    chk("t2_owner", owner, 1);
    tick();
    chk("t2_en_we_c2", {mem_en, mem_we}, 2'b11);
    tick();
    chk("t2_ldr_ack", ldr_if.ack, 1);
    chk("t2_cpu_ack", cpu_if.ack, 0);
    chk("t2_we_resp", {mem_en, mem_we}, 0);
    chk("t2_ldr_rdata", ldr_if.rdata, 0);
    chk("t2_cpu_rdata", cpu_if.rdata, 16'hE207);
    ldr_if.req = 1'b0;
    tick();
    chk("t2_ack_clr", ldr_if.ack, 0);

    // 3: both requesting continuously after reset
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    cpu_if.req = 1'b1; cpu_if.we = 1'b0; cpu_if.addr = 16'h4000;
    ldr_if.req = 1'b1; ldr_if.we = 1'b0; ldr_if.addr = 16'h5000;
    mem_rdata = 16'h1111;
    for (int i = 0; i < 4; i++) begin
`ifdef MEMARB_LDR_PRIORITY_EN
      exp_own = 1'b1;
`else
      exp_own = (i % 2 == 0);
`endif
      tick();
      chk("t3_owner", owner, exp_own);
      chk("t3_addr", mem_addr, exp_own ? 16'h5000 : 16'h4000);
      tick();
      tick();
      chk("t3_acks", {ldr_if.ack, cpu_if.ack}, exp_own ? 2'b10 : 2'b01);
      if (i == 3) begin
        cpu_if.req = 1'b0;
        ldr_if.req = 1'b0;
      end
      tick();
    end
    chk("t3_idle", busy, 0);

    // 4: CPU drops req during ACCESS
    cpu_if.req = 1'b1; cpu_if.we = 1'b0; cpu_if.addr = 16'h3005; mem_rdata = 16'h1234;
    tick();
    cpu_if.req = 1'b0;
    tick();
    tick();
    chk("t4_ack", cpu_if.ack, 1);
    chk("t4_rdata", cpu_if.rdata, 16'h1234);
    tick();
    tick();
    chk("t4_no_second", {busy, mem_en}, 0);

    // 5: reset during ACCESS aborts, then a fresh request is served
    cpu_if.req = 1'b1; cpu_if.addr = 16'h3006; mem_rdata = 16'h5555;
    tick();
    chk("t5_busy", busy, 1);
    rst_n = 1'b0;
    tick();
    chk("t5_abort", {mem_en, busy, cpu_if.ack}, 0);
    rst_n = 1'b1;
    tick();
    chk("t5_restart", {mem_en, mem_addr}, {1'b1, 16'h3006});
    tick();
    tick();
    chk("t5_ack", cpu_if.ack, 1);
    chk("t5_rdata", cpu_if.rdata, 16'h5555);
    cpu_if.req = 1'b0;
    tick();

    // 6: back-to-back CPU reads
    cpu_if.req = 1'b1; cpu_if.addr = 16'h3010; mem_rdata = 16'h0F0F;
    n = 0;
    for (int c = 1; c <= 30 && n < 3; c++) begin
      tick();
      if (cpu_if.ack) begin
        t[n] = c;
        n++;
        if (n == 3) cpu_if.req = 1'b0;
      end
    end
    chk("t6_ack_count", n, 3);
    if (n == 3) begin
      chk("t6_first", t[0], 3);
      chk("t6_gap1", t[1] - t[0], 4);
      chk("t6_gap2", t[2] - t[1], 4);
    end
    tick();
    tick();
    chk("t6_idle", busy, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
